// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: controller state encoding, ALU opcode constants and default widths
package uart_alu_pkg;
   localparam int DBIT_DEF = 8;
   localparam int OP_W_DEF = 6;
   typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
endpackage

// File: rtl/uart_alu_ctrl_frame_timer.sv
// frame_timer: inter-byte timeout counter; clr zeroes it, en counts, expire flags the last cycle
// Ports: clk, reset (async, active-high), clr, en in; expire out (high while en and count == TIMEOUT_CYC-1)
module frame_timer #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects A, B, opcode bytes from uart_rx, drives the ALU, sends the result via uart_tx
// Ports: clk, reset (async, active-high); rx_done_tick/rx_data from receiver; tx_done_tick and
// alu_result in; alu_a, alu_b, alu_op, tx_start, tx_data, busy, err_overrun (sticky) out.
// Macro UART_ALU_FRAME_TIMEOUT_EN adds a TIMEOUT_CYC inter-byte timeout and a timeout_tick output.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int DBIT        = DBIT_DEF,
   parameter int OP_W        = OP_W_DEF,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_done_tick,
   input  logic [DBIT-1:0] rx_data,
   input  logic            tx_done_tick,
   input  logic [DBIT-1:0] alu_result,
   output logic [DBIT-1:0] alu_a,
   output logic [DBIT-1:0] alu_b,
   output logic [OP_W-1:0] alu_op,
   output logic            tx_start,
   output logic [DBIT-1:0] tx_data,
   output logic            busy,
   output logic            err_overrun
`ifdef UART_ALU_FRAME_TIMEOUT_EN
   ,output logic           timeout_tick
`endif
);
   if (OP_W > DBIT || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("uart_alu_ctrl: OP_W must fit in DBIT and TIMEOUT_CYC must be >= 2");
   end
   state_t state, state_n;
   logic tmo;
`ifdef UART_ALU_FRAME_TIMEOUT_EN
   logic expire;
   frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (rx_done_tick || state_n == WAIT_A),
      .en    (state == WAIT_B || state == WAIT_OP),
      .expire(expire)
   );
   // a byte arriving on the final cycle still counts as on time
   assign timeout_tick = expire && !rx_done_tick;
   assign tmo = timeout_tick;
`else
   assign tmo = 1'b0;
`endif
   assign busy     = state == EXEC || state == SEND || state == WAIT_TX;
   assign tx_start = state == SEND;
   always_comb begin
      state_n = state;
      case (state)
         WAIT_A:  state_n = rx_done_tick ? WAIT_B : WAIT_A;
         WAIT_B:  state_n = rx_done_tick ? WAIT_OP : tmo ? WAIT_A : WAIT_B;
         WAIT_OP: state_n = rx_done_tick ? EXEC : tmo ? WAIT_A : WAIT_OP;
         EXEC:    state_n = SEND;
         SEND:    state_n = WAIT_TX;
         WAIT_TX: state_n = tx_done_tick ? WAIT_A : WAIT_TX;
         default: state_n = WAIT_A;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= WAIT_A;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         tx_data     <= '0;
         err_overrun <= 1'b0;
      end else begin
         state <= state_n;
         if (rx_done_tick && state == WAIT_A) alu_a <= rx_data;
         if (rx_done_tick && state == WAIT_B) alu_b <= rx_data;
         if (rx_done_tick && state == WAIT_OP) alu_op <= rx_data[OP_W-1:0];
         if (state == EXEC) tx_data <= alu_result;
         if (rx_done_tick && busy) err_overrun <= 1'b1;
      end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: table-driven frames with a tx scoreboard, plus reset/overrun/timeout sequences
module tb_uart_alu_ctrl;
   import uart_alu_pkg::*;
   localparam int TCYC = 16;
   logic clk = 0, reset = 1, rx_done_tick = 0, tx_done_tick = 0;
   logic [7:0] rx_data = 0, alu_result, alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic tx_start, busy, err_overrun;
`ifdef UART_ALU_FRAME_TIMEOUT_EN
   logic timeout_tick;
`endif
   int cmp = 0, bad = 0, cyc = 0, starts = 0, tick_cyc = 0;
   typedef struct {logic [7:0] d; int c;} exp_t;
   typedef struct {logic [7:0] a; logic [7:0] b; logic [5:0] op; logic [7:0] exp; int mode;} vec_t;
   exp_t sb[$];
   vec_t vt[7];

   uart_alu_ctrl #(.DBIT(8), .OP_W(6), .TIMEOUT_CYC(TCYC)) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .tx_done_tick(tx_done_tick), .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
      .err_overrun(err_overrun)
`ifdef UART_ALU_FRAME_TIMEOUT_EN
      , .timeout_tick(timeout_tick)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         OP_ADD: alu_result = alu_a + alu_b;
         OP_SUB: alu_result = alu_a - alu_b;
         OP_AND: alu_result = alu_a & alu_b;
         OP_OR:  alu_result = alu_a | alu_b;
         OP_XOR: alu_result = alu_a ^ alu_b;
         OP_NOR: alu_result = ~(alu_a | alu_b);
         OP_SRA: alu_result = $signed(alu_a) >>> alu_b;
         OP_SRL: alu_result = alu_a >> alu_b;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask

   always @(negedge clk) if (tx_start === 1'b1) begin : mon
      exp_t e;
      starts++;
      if (sb.size() == 0) chk("tx_start_unexpected", 1, 0);
      else begin
         e = sb.pop_front();
         chk("tx_data_at_start", tx_data, e.d);
         chk("tx_start_cycle", cyc, e.c);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_done_tick = 1;
      tick_cyc = cyc;
      @(posedge clk); #1;
      rx_done_tick = 0;
   endtask

   task automatic pulse_tx_done();
      @(posedge clk); #1 tx_done_tick = 1;
      @(posedge clk); #1 tx_done_tick = 0;
   endtask

   task automatic run_frame(input vec_t v, input logic exp_err);
      int s0;
      s0 = starts;
      send_byte(v.a);
      if (v.mode == 2) begin
         pulse_tx_done();
         chk("busy_after_tx_done_in_wait_b", busy, 0);
      end
      send_byte(v.b);
      send_byte(v.op);
      sb.push_back('{v.exp, tick_cyc + 2});
      chk("alu_a", alu_a, v.a);
      chk("alu_b", alu_b, v.b);
      chk("alu_op", alu_op, v.op);
      repeat (4) @(negedge clk);
      #1;
      chk("tx_start_count", starts, s0 + 1);
      chk("busy_wait_tx", busy, 1);
      chk("tx_data_stable", tx_data, v.exp);
      if (v.mode == 1) begin
         send_byte(8'hAA);
         @(negedge clk);
         chk("err_overrun_set", err_overrun, 1);
         chk("alu_a_kept", alu_a, v.a);
         chk("alu_b_kept", alu_b, v.b);
         chk("busy_after_overrun", busy, 1);
         chk("no_extra_start", starts, s0 + 1);
      end
      pulse_tx_done();
      @(negedge clk);
      chk("busy_after_tx_done", busy, 0);
      chk("err_overrun", err_overrun, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'h05, 8'h03, OP_ADD, 8'h08, 0};
      vt[1] = '{8'hF0, 8'h0F, OP_XOR, 8'hFF, 0};
      vt[2] = '{8'h10, 8'h20, OP_SUB, 8'hF0, 0};
      vt[3] = '{8'hC3, 8'h3C, OP_AND, 8'h00, 1};
      vt[4] = '{8'h80, 8'h02, OP_SRA, 8'hE0, 0};
      vt[5] = '{8'h0A, 8'h50, OP_NOR, 8'hA5, 2};
      vt[6] = '{8'h12, 8'h34, OP_OR,  8'h36, 0};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_overrun, 0);
      reset = 0;
      for (int i = 0; i < 7; i++) run_frame(vt[i], i >= 3);
      send_byte(8'h55);
      chk("partial_alu_a", alu_a, 8'h55);
      @(posedge clk);
      #3 reset = 1;
      #1;
      chk("async_rst_alu_a", alu_a, 0);
      chk("async_rst_alu_b", alu_b, 0);
      chk("async_rst_alu_op", alu_op, 0);
      chk("async_rst_tx_data", tx_data, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_err", err_overrun, 0);
      @(negedge clk) reset = 0;
      run_frame('{8'h07, 8'h02, OP_SRL, 8'h01, 0}, 1'b0);
`ifdef UART_ALU_FRAME_TIMEOUT_EN
      begin
         int n, at;
         n = 0;
         at = -1;
         send_byte(8'h99);
         repeat (20) begin
            @(negedge clk);
            if (timeout_tick === 1'b1) begin
               n++;
               at = cyc;
            end
         end
         chk("timeout_pulses", n, 1);
         chk("timeout_cycle", at, tick_cyc + TCYC);
         chk("timeout_keeps_alu_a", alu_a, 8'h99);
         chk("timeout_busy", busy, 0);
         run_frame('{8'h21, 8'h21, OP_ADD, 8'h42, 0}, 1'b0);
      end
`endif
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
